// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// scan-code prefixes and the key codes the snake game reacts to.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_R     = 8'h2D;

  // Odd parity: data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserializer: synchronizes the raw pins, detects PS2_CLK falling
// edges and assembles 11-bit frames (start, 8 data LSB-first, parity, stop).
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking.
// Ports:
//   clk, rst_n      - system clock, async active-low reset
//   ps2_clk/data    - raw asynchronous keyboard pins
//   byte_valid_c    - single-cycle strobe, byte_data_c holds a good byte
//   byte_data_c     - received byte
//   frame_err_c     - single-cycle strobe, frame discarded (stop/parity/timeout)
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid_c,
  output logic [7:0] byte_data_c,
  output logic       frame_err_c
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  ps2_state_e       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`ifdef PS2_PARITY_CHECK_EN
  logic             parity_q, parity_d;
`endif

  logic fall;
  logic din;
  logic par_ok;

  // s1 = bit 0, s2 = bit 1, s3 = bit 2
  assign fall        = ~clk_sync_q[1] & clk_sync_q[2];
  assign din         = data_sync_q[1];
  assign byte_data_c = shift_q;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = odd_parity_ok(shift_q, parity_q);
`else
  assign par_ok = 1'b1;
`endif

  // Next-state, shift register and timeout logic
  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
`ifdef PS2_PARITY_CHECK_EN
    parity_d     = parity_q;
`endif
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;

    if (fall) begin
      tmo_d = '0;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          // A high data bit on an edge here is spurious, not a start bit.
          if (!din) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = din;
`endif
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (din && par_ok) begin
            byte_valid_c = 1'b1;
          end else begin
            frame_err_c = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      // Keyboard stopped clocking mid-frame: abandon it.
      state_d     = ST_IDLE;
      tmo_d       = '0;
      frame_err_c = 1'b1;
    end
  end

  // State registers; synchronizers preset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      tmo_q       <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard scan-code receiver for the snake game. Strips E0/F0 prefixes,
// holds the last make code and returns it to 0x00 on the matching break.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of frames.
// Ports:
//   CLK25MHz, RESET_N  - system clock, async active-low reset
//   PS2_CLK, PS2_DATA  - raw keyboard pins
//   keycode            - last make code, 0x00 after its break
//   keycode_ext        - keycode arrived with an E0 prefix
//   new_key            - one-cycle pulse on each make-code update
//   frame_err          - one-cycle pulse when a frame is discarded
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       CLK25MHz,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] keycode,
  output logic       keycode_ext,
  output logic       new_key,
  output logic       frame_err
);

  logic       rx_valid_c;
  logic [7:0] rx_byte_c;
  logic       rx_err_c;

  logic [7:0] keycode_q, keycode_d;
  logic       ext_q, ext_d;
  logic       new_key_q, new_key_d;
  logic       frame_err_q, frame_err_d;
  logic       e0_q, e0_d;
  logic       f0_q, f0_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (CLK25MHz),
    .rst_n       (RESET_N),
    .ps2_clk     (PS2_CLK),
    .ps2_data    (PS2_DATA),
    .byte_valid_c(rx_valid_c),
    .byte_data_c (rx_byte_c),
    .frame_err_c (rx_err_c)
  );

  // Prefix decoder
  always_comb begin
    keycode_d   = keycode_q;
    ext_d       = ext_q;
    new_key_d   = 1'b0;
    frame_err_d = rx_err_c;
    e0_d        = e0_q;
    f0_d        = f0_q;

    if (rx_valid_c) begin
      if (rx_byte_c == PS2_EXT) begin
        e0_d = 1'b1;
      end else if (rx_byte_c == PS2_BREAK) begin
        f0_d = 1'b1;
      end else if (f0_q) begin
        // Only releasing the held key clears it; other breaks are ignored.
        if (rx_byte_c == keycode_q) begin
          keycode_d = 8'h00;
          ext_d     = 1'b0;
        end
        e0_d = 1'b0;
        f0_d = 1'b0;
      end else begin
        // Repeats of the same key still pulse new_key.
        keycode_d = rx_byte_c;
        ext_d     = e0_q;
        new_key_d = 1'b1;
        e0_d      = 1'b0;
        f0_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK25MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      keycode_q   <= 8'h00;
      ext_q       <= 1'b0;
      new_key_q   <= 1'b0;
      frame_err_q <= 1'b0;
      e0_q        <= 1'b0;
      f0_q        <= 1'b0;
    end else begin
      keycode_q   <= keycode_d;
      ext_q       <= ext_d;
      new_key_q   <= new_key_d;
      frame_err_q <= frame_err_d;
      e0_q        <= e0_d;
      f0_q        <= f0_d;
    end
  end

  assign keycode     = keycode_q;
  assign keycode_ext = ext_q;
  assign new_key     = new_key_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: directed PS/2 frames push expected
// output events; a monitor pops and compares whenever outputs change or pulse.
module tb_ps2_keycode_rx;

  localparam int HALF = 20;

  typedef struct packed {
    logic       nk;
    logic       fe;
    logic [7:0] kc;
    logic       ext;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       keycode_ext;
  logic       new_key;
  logic       frame_err;

  int vectors;
  int errors;
  ev_t exp_q[$];

  ps2_keycode_rx #(.TIMEOUT_CYCLES(25000)) dut (
    .CLK25MHz   (clk),
    .RESET_N    (rst_n),
    .PS2_CLK    (ps2_clk),
    .PS2_DATA   (ps2_data),
    .keycode    (keycode),
    .keycode_ext(keycode_ext),
    .new_key    (new_key),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic push(input logic nk, input logic fe, input logic [7:0] kc, input logic ext);
    ev_t e;
    e.nk = nk; e.fe = fe; e.kc = kc; e.ext = ext;
    exp_q.push_back(e);
  endtask

  // Full frame; chk_lat verifies new_key rises on the 3rd edge after the stop fall.
  task automatic send_frame(input logic [7:0] b, input bit good_par, input bit chk_lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good_par ? ~^b : ^b);
    ps2_data = 1'b1;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    if (chk_lat) begin
      repeat (2) @(posedge clk);
      #1 check("latency_edge2", {15'd0, new_key}, 16'd0);
      @(posedge clk);
      #1 check("latency_edge3", {15'd0, new_key}, 16'd1);
    end
    wait_cycles(HALF);
    ps2_clk = 1'b1;
    wait_cycles(10);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_keycode"}, {8'd0, keycode}, 16'd0);
    check({tag, "_ext"}, {15'd0, keycode_ext}, 16'd0);
    check({tag, "_new_key"}, {15'd0, new_key}, 16'd0);
    check({tag, "_frame_err"}, {15'd0, frame_err}, 16'd0);
  endtask

  // Monitor: any pulse or change of keycode/keycode_ext is one event.
  initial begin
    logic [7:0] prev_kc;
    logic       prev_ext;
    ev_t        got, want;
    prev_kc  = 8'h00;
    prev_ext = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 &&
          (new_key || frame_err || keycode !== prev_kc || keycode_ext !== prev_ext)) begin
        got.nk = new_key; got.fe = frame_err; got.kc = keycode; got.ext = keycode_ext;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got nk=%b fe=%b kc=%h ext=%b expected none",
                   got.nk, got.fe, got.kc, got.ext);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event: got nk=%b fe=%b kc=%h ext=%b expected nk=%b fe=%b kc=%h ext=%b",
                     got.nk, got.fe, got.kc, got.ext, want.nk, want.fe, want.kc, want.ext);
          end
        end
      end
      prev_kc  = keycode;
      prev_ext = keycode_ext;
    end
  end

  initial begin
    logic [7:0] cur_kc;
    logic [7:0] f0_byte;
    vectors  = 0;
    errors   = 0;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_cycles(5);

    // S key, with latency check
    push(1'b1, 1'b0, 8'h1B, 1'b0);
    send_frame(8'h1B, 1'b1, 1'b1);

    // Extended up arrow make, then its extended break
    push(1'b1, 1'b0, 8'h75, 1'b1);
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b1, 1'b0);
    check("up_ext", {15'd0, keycode_ext}, 16'd1);
    push(1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b1, 1'b0);

    // Left make, then break of a different key leaves it held
    push(1'b1, 1'b0, 8'h6B, 1'b0);
    send_frame(8'h6B, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h72, 1'b1, 1'b0);
    check("other_break_hold", {8'd0, keycode}, 16'h006B);

    // P key with wrong parity
`ifdef PS2_PARITY_CHECK_EN
    push(1'b0, 1'b1, 8'h6B, 1'b0);
    cur_kc = 8'h6B;
`else
    push(1'b1, 1'b0, 8'h4D, 1'b0);
    cur_kc = 8'h4D;
`endif
    send_frame(8'h4D, 1'b0, 1'b0);
    check("bad_parity_kc", {8'd0, keycode}, {8'd0, cur_kc});

    // Partial frame then timeout
    push(1'b0, 1'b1, cur_kc, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cycles(25200);
    push(1'b1, 1'b0, 8'h76, 1'b0);
    send_frame(8'h76, 1'b1, 1'b0);
    // Typematic repeat of the same key still pulses new_key
    push(1'b1, 1'b0, 8'h76, 1'b0);
    send_frame(8'h76, 1'b1, 1'b0);
    check("after_timeout_kc", {8'd0, keycode}, 16'h0076);

    // Reset during bit 5 of an F0 frame; remaining bits are all ones
    f0_byte = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(f0_byte[i]);
    wait_cycles(2);
    rst_n = 1'b0;
    wait_cycles(2);
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    for (int i = 5; i < 8; i++) send_bit(f0_byte[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_cycles(10);
    check("after_midreset_kc", {8'd0, keycode}, 16'h0000);
    push(1'b1, 1'b0, 8'h2D, 1'b0);
    send_frame(8'h2D, 1'b1, 1'b0);
    check("final_kc", {8'd0, keycode}, 16'h002D);

    wait_cycles(100);
    check("events_outstanding", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

Receives scan codes from a PS/2 keyboard and presents them as the 8-bit `keycode` consumed by the snake game's pixel and game-logic block. It synchronizes the raw PS/2 clock and data pins into the 25 MHz domain and deserializes 11-bit frames. It strips the E0 (extended) and F0 (break) prefixes. It returns `keycode` to 0x00 when the held key is released, so the consumer's change detection sees every new press, including a repeat of the same key.

## Interface
- `TIMEOUT_CYCLES`, default 25000: number of CLK25MHz cycles without a PS/2 falling edge after which a partial frame is abandoned (1 ms).
- `CLK25MHz` input 1: system clock, 25 MHz.
- `RESET_N` input 1: asynchronous, active-low reset.
- `PS2_CLK` input 1: raw keyboard clock pin, asynchronous to CLK25MHz.
- `PS2_DATA` input 1: raw keyboard data pin, asynchronous to CLK25MHz.
- `keycode` output 8: last make code, or 0x00 after the matching break.
- `keycode_ext` output 1: set when the current `keycode` arrived with an E0 prefix.
- `new_key` output 1: one-cycle pulse on every make-code update of `keycode`.
- `frame_err` output 1: one-cycle pulse when a frame is discarded.

## Operation
- **Reset:** all of the following clear to 0 while RESET_N is low:
  - `keycode` = 0x00, `keycode_ext` = 0, `new_key` = 0, `frame_err` = 0.
  - Frame FSM state = IDLE; E0 flag, F0 flag and timeout counter cleared.
  - Synchronizer stages preset to 1 (idle bus).
- **Synchronizer and edge detection:**
  - PS2_CLK passes through three flops (`s1`, `s2`, `s3`); PS2_DATA passes through two.
  - A falling edge is detected when `s2`==0 and `s3`==1.
  - Data is sampled from the data `s2` in that same cycle.
- **Frame FSM** (all transitions occur on a detected falling edge):
  - IDLE: data 0 → DATA with bit count 0. Data 1 is ignored (spurious edge).
  - DATA: shift the sampled bit in LSB-first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop==1 and parity is OK, deliver the byte to the decoder; otherwise pulse `frame_err`. Either way → IDLE.
- **Timeout:**
  - The counter resets on every falling edge and counts while state != IDLE.
  - When the count reaches TIMEOUT_CYCLES-1: → IDLE and pulse `frame_err`.
- **Decoder**, acting on each delivered byte:
  - 0xE0: set the E0 flag; no output change.
  - 0xF0: set the F0 flag; no output change.
  - Other byte with F0 set: if byte == `keycode`, then `keycode` ← 0x00 and `keycode_ext` ← 0. Otherwise no output change. Clear both flags.
  - Other byte with F0 clear: `keycode` ← byte, `keycode_ext` ← E0 flag, pulse `new_key`, clear both flags. This applies even when the byte equals the current `keycode` (typematic repeat).
- **Reset mid-frame:** the partial frame is lost; the FSM does not resync until the next start bit after RESET_N deasserts.

## Timing
- Latency: a PS2_CLK falling edge at the pin becomes visible as a detected edge after 2 CLK25MHz rising edges.
- `keycode`, `keycode_ext`, `new_key` and `frame_err` update on the 3rd CLK25MHz rising edge after the stop-bit falling edge at the pin.
- `new_key` and `frame_err` are high for exactly one cycle.
- `keycode` holds its value between updates.
- The minimum PS/2 clock half-period (30 µs, 750 cycles) far exceeds the pipeline depth, so back-to-back frames need no buffering.
- No deglitch filter beyond the synchronizer; PS2_CLK is assumed monotonic within 3 cycles.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - Odd parity is checked: data bits plus parity bit must contain an odd number of 1s.
  - A mismatch discards the byte and pulses `frame_err`; the decoder flags are left unchanged.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is captured but ignored.
  - Only a bad stop bit or a timeout raises `frame_err`.

## Structure
- Shared package `ps2_pkg` holds:
  - The FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Constants PS2_EXT = 0xE0 and PS2_BREAK = 0xF0.
  - The arrow/control key constants used by the game: 0x75, 0x72, 0x6B, 0x74, 0x76, 0x1B, 0x4D, 0x2D.
- One natural sub-module, `ps2_frame_rx`, contains the synchronizer, edge detection, frame FSM and timeout. It outputs `byte_valid`, `byte` and `frame_err`.
- The E0/F0 decoder stays in the top level.

## Test plan
- Frame 0x1B (S), parity 1, stop 1 → `keycode`=0x1B, `keycode_ext`=0, `new_key` pulses once.
- Frames E0, 75 → `keycode`=0x75, `keycode_ext`=1. Then frames E0, F0, 75 → `keycode`=0x00, `keycode_ext`=0, no `new_key` pulse.
- Frames 6B, then F0, 72 (break of a different key) → `keycode` stays 0x6B.
- Frame 0x4D with parity 0:
  - With `PS2_PARITY_CHECK_EN`: `frame_err` pulses and `keycode` is unchanged.
  - Without it: `keycode`=0x4D.
- 4 data bits, then PS2_CLK idle for 25000 cycles → `frame_err` pulses and the FSM returns to IDLE. A following valid 0x76 frame → `keycode`=0x76.
- RESET_N low for 2 cycles during bit 5 of a frame → all outputs 0. The remainder of the interrupted frame produces no output. The next full 0x2D frame → `keycode`=0x2D.
